pipe_stage_reg: RTL
===================

Name: pipe_stage_reg

Overview:
Parametrised successor to the fixed inter-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB). Carries one control bundle and one data bundle per instruction using a valid/ready handshake. A 2-entry skid buffer lets a downstream stall back-pressure upstream without a combinational ready path. Supports flush-to-bubble and forces control fields inert whenever no valid instruction is held.

Parameters:
DATA_W, 128, width of data bundle (e.g. ALU result, store data, branch target, offset)
CTRL_W, 16, width of control bundle (RegWrite, MemWrite, MemRead, MemToReg, Branch, dataType, ...)
CLEAR_DATA, 0, 1 = flush/reset also zeroes data registers; 0 = data regs hold stale values (only control cleared)
CNT_W, 16, width of statistics counters (optional feature)

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
flush  in  1  synchronous flush; discards all held and incoming entries
in_valid  in  1  upstream has an entry
in_ready  out  1  stage can accept; registered, depends only on state
in_ctrl  in  CTRL_W  upstream control bundle
in_data  in  DATA_W  upstream data bundle
out_valid  out  1  stage presents a valid entry
out_ready  in  1  downstream accepts
out_ctrl  out  CTRL_W  control bundle; all zero when out_valid=0
out_data  out  DATA_W  data bundle
occupancy  out  2  entries held (0..2)
stall_cycles  out  CNT_W  statistics (optional feature)
bubble_cycles  out  CNT_W  statistics (optional feature)
flush_count  out  CNT_W  statistics (optional feature)

Behaviour:
- Reset (async, active-high): state EMPTY; out_valid=0, out_ctrl=0, out_data=0, occupancy=0, in_ready=1 (registered value), all counters 0, skid regs 0.
- Handshakes: accept = in_valid & in_ready; send = out_valid & out_ready; both are sampled at the rising edge.
- States: EMPTY (occ 0), ONE (main full), TWO (main + skid full). in_ready = (state != TWO), taken from a register.
- EMPTY: accept -> ONE with main <= in; otherwise stay.
- ONE: accept & !send -> TWO with skid <= in. accept & send -> ONE with main <= in. !accept & send -> EMPTY. Neither -> hold.
- TWO: in_ready=0, so accept is impossible. send -> ONE with main <= skid. Otherwise hold.
- Ordering is strictly FIFO. No entry is duplicated or dropped except on flush.
- Latency: an entry accepted at edge N appears at out_* after edge N (1 cycle) when the stage is EMPTY or draining.
- out_ctrl = main_ctrl when out_valid, else 0. out_data = main_data regardless of valid.
- Flush (sync) has the highest priority over accept and send. Next state is EMPTY, out_valid=0, ctrl regs=0. Data regs are zeroed only if CLEAR_DATA=1. An entry offered in the flush cycle is dropped, even if in_ready=1. in_ready=1 the cycle after.
- Reset mid-transfer: immediate EMPTY, and no entry survives.
- in_ctrl/in_data may change freely when in_valid=0. Upstream must hold them stable while in_valid & !in_ready. The stage does not check this.

Optional Feature:
Macro PIPE_STAGE_STATS_EN.
- Defined:
  - stall_cycles increments each cycle out_valid & !out_ready.
  - bubble_cycles increments each cycle !out_valid.
  - flush_count increments each cycle flush=1.
  - All three saturate at 2^CNT_W-1, are cleared only by reset (not flush), and are updated at the same edge as the event.
- Not defined: counter logic is omitted and the three ports are tied to constant 0.

Test Plan:
1. Reset then stream: out_ready=1, push ctrl 0x0001..0x0005 on consecutive cycles -> each appears 1 cycle later, out_valid stays 1, occupancy=1, in_ready=1 throughout.
2. Back-pressure: fill with A=0x11, then hold out_ready=0 and offer B=0x22, C=0x33 -> B enters skid, occupancy=2, in_ready=0, C held upstream. Release out_ready -> outputs A, B, C in order, none lost.
3. Flush in TWO with in_valid=1 (D=0x44) -> next cycle out_valid=0, out_ctrl=0, occupancy=0, in_ready=1, D never appears. With CLEAR_DATA=1, out_data=0.
4. Async reset asserted mid-cycle while occupancy=2 -> out_valid=0 and out_ctrl=0 immediately without a clock edge, in_ready=1 after release.
5. Bubble gating: in_valid=0 for 3 cycles with nonzero in_ctrl -> out_ctrl remains 0, out_valid=0.
6. PIPE_STAGE_STATS_EN, CNT_W=2: stall 5 cycles -> stall_cycles=3 (saturated). 2 flushes -> flush_count=2, and it is not cleared by the flush itself.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline register with a 2-entry skid buffer, flush-to-bubble and gated control output.
// Optional saturating statistics counters are built only when PIPE_STAGE_STATS_EN is defined.
module pipe_stage_reg #(
  parameter int DATA_W     = 128,
  parameter int CTRL_W     = 16,
  parameter bit CLEAR_DATA = 1'b0,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic [CNT_W-1:0]  bubble_cycles,
  output logic [CNT_W-1:0]  flush_count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } stateT;

  stateT             state, nextState;
  logic              inReadyQ;
  logic [CTRL_W-1:0] mainCtrl, skidCtrl;
  logic [DATA_W-1:0] mainData, skidData;
  logic              accept, send;
  logic              loadMainFromIn, loadMainFromSkid, loadSkid;

  assign accept    = in_valid & inReadyQ;
  assign send      = out_valid & out_ready;
  assign out_valid = (state != EMPTY);
  assign in_ready  = inReadyQ;
  assign occupancy = state;
  assign out_ctrl  = out_valid ? mainCtrl : '0;
  assign out_data  = mainData;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    nextState        = state;
    loadMainFromIn   = 1'b0;
    loadMainFromSkid = 1'b0;
    loadSkid         = 1'b0;
    unique case (state)
      EMPTY: begin
        if (accept) begin
          nextState      = ONE;
          loadMainFromIn = 1'b1;
        end
      end
      ONE: begin
        if (accept && !send) begin
          nextState = TWO;
          loadSkid  = 1'b1;
        end else if (accept && send) begin
          loadMainFromIn = 1'b1;
        end else if (send) begin
          nextState = EMPTY;
        end
      end
      TWO: begin
        if (send) begin
          nextState        = ONE;
          loadMainFromSkid = 1'b1;
        end
      end
      default: nextState = EMPTY;
    endcase
    if (flush) nextState = EMPTY;
  end

  // in_ready is registered from the next state, so it never depends combinationally on out_ready.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: the data registers are reset too, because out_data must read zero straight out of reset.
    if (reset) begin
      state    <= EMPTY;
      inReadyQ <= 1'b1;
      mainCtrl <= '0;
      skidCtrl <= '0;
      mainData <= '0;
      skidData <= '0;
    end else if (flush) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
      state    <= EMPTY;
      inReadyQ <= 1'b1;
      mainCtrl <= '0;
      skidCtrl <= '0;
      if (CLEAR_DATA) begin
        mainData <= '0;
        skidData <= '0;
      end
    end else begin
      state    <= nextState;
      inReadyQ <= (nextState != TWO);
      if (loadMainFromIn) begin
        mainCtrl <= in_ctrl;
        mainData <= in_data;
      end else if (loadMainFromSkid) begin
        mainCtrl <= skidCtrl;
        mainData <= skidData;
      end
      if (loadSkid) begin
        skidCtrl <= in_ctrl;
        skidData <= in_data;
      end
    end
  end

`ifdef PIPE_STAGE_STATS_EN
  logic [CNT_W-1:0] stallQ, bubbleQ, flushQ;

  // Counters saturate at all-ones and survive flush; only reset clears them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stallQ  <= '0;
      bubbleQ <= '0;
      flushQ  <= '0;
    end else begin
      if (out_valid && !out_ready && (stallQ != '1)) stallQ <= stallQ + CNT_W'(1);
      if (!out_valid && (bubbleQ != '1))            bubbleQ <= bubbleQ + CNT_W'(1);
      if (flush && (flushQ != '1))                  flushQ <= flushQ + CNT_W'(1);
    end
  end

  assign stall_cycles  = stallQ;
  assign bubble_cycles = bubbleQ;
  assign flush_count   = flushQ;
`else
  assign stall_cycles  = '0;
  assign bubble_cycles = '0;
  assign flush_count   = '0;
`endif

endmodule
